// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// Module      : uart_rx_frame
// Description : 8N1 UART receive front end. It has a two-flop input
//               synchroniser, start-bit glitch rejection, 3-sample majority
//               voting and framing-error detection. A frame in progress is
//               shown on busy, and each good byte is announced by a one-clock
//               rxdDataReady strobe.
//               Optional macro UART_RX_PARITY_EN inserts an even-parity bit
//               between the data bits and the stop bit, and adds a
//               parityError strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       rxdDataReady,
    output logic       frameError,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parityError
`endif
);

    localparam int c_DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIVW = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_SCW  = $clog2(OVERSAMPLE);

    localparam logic [c_DIVW-1:0] c_DIV_MAX  = c_DIVW'(c_DIV - 1);
    localparam logic [c_SCW-1:0]  c_SC_LAST  = c_SCW'(OVERSAMPLE - 1);
    localparam logic [c_SCW-1:0]  c_SC_MID   = c_SCW'(OVERSAMPLE / 2);
    localparam logic [c_SCW-1:0]  c_SC_MIDM1 = c_SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SCW-1:0]  c_SC_MIDM2 = c_SCW'(OVERSAMPLE / 2 - 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd5,
`endif
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxs;
    logic [c_DIVW-1:0] r_div;
    logic              w_tick;
    logic [c_SCW-1:0]  r_sc;
    logic              r_smp_a;
    logic              r_smp_b;
    logic              w_vote;
    logic [2:0]        r_bitidx;
    logic [7:0]        r_shreg;
    logic              w_shift;
    logic              w_load;
    logic              w_ferr;
    logic              w_sc_clr;
`ifdef UART_RX_PARITY_EN
    logic              r_par;
    logic              w_par_cap;
    logic              w_perr;
`endif

    assign w_rxs  = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_div == c_DIV_MAX);
    // Decision sample is the live one; the two earlier samples are held.
    assign w_vote = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
    assign busy   = (r_state != S_IDLE);

    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        w_sc_clr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_cap   = 1'b0;
        w_perr      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick && (r_sc == c_SC_MIDM1) && w_rxs) w_state_nxt = S_IDLE;
                else if (w_tick && (r_sc == c_SC_LAST))      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_sc == c_SC_MID)) w_shift = 1'b1;
                if (w_tick && (r_sc == c_SC_LAST) && (r_bitidx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick && (r_sc == c_SC_MID))  w_par_cap   = 1'b1;
                if (w_tick && (r_sc == c_SC_LAST)) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick && (r_sc == c_SC_MID)) begin
                    if (w_vote) begin
                        // Return to IDLE mid stop bit so back-to-back frames work.
                        w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{r_shreg, r_par}) w_perr = 1'b1;
                        else                   w_load = 1'b1;
`else
                        w_load = 1'b1;
`endif
                    end else begin
                        w_ferr      = 1'b1;
                        w_sc_clr    = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_tick && w_rxs && (r_sc == c_SC_LAST)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Baud tick divider and sample counter; sc doubles as the high-run counter in WAIT_IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_sc  <= '0;
        end else if (r_state == S_IDLE) begin
            r_div <= '0;
            r_sc  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_DIVW'(1);
            if (w_sc_clr || ((r_state == S_WAIT_IDLE) && !w_rxs))
                r_sc <= '0;
            else if (w_tick)
                r_sc <= (r_sc == c_SC_LAST) ? '0 : r_sc + c_SCW'(1);
        end
    end

    // Sample capture, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_smp_a  <= 1'b0;
            r_smp_b  <= 1'b0;
            r_bitidx <= 3'd0;
            r_shreg  <= 8'h00;
        end else begin
            if (w_tick && (r_sc == c_SC_MIDM2)) r_smp_a <= w_rxs;
            if (w_tick && (r_sc == c_SC_MIDM1)) r_smp_b <= w_rxs;
            if (r_state == S_IDLE)
                r_bitidx <= 3'd0;
            else if ((r_state == S_DATA) && w_tick && (r_sc == c_SC_LAST))
                r_bitidx <= r_bitidx + 3'd1;
            if (w_shift) r_shreg <= {w_vote, r_shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Received parity bit, checked against the data at the stop decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_par <= 1'b0;
        else if (w_par_cap) r_par <= w_vote;
    end

    // Parity error strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parityError <= 1'b0;
        else        parityError <= w_perr;
    end
`endif

    // Registered result strobes and output byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data         <= 8'h00;
            rxdDataReady <= 1'b0;
            frameError   <= 1'b0;
        end else begin
            if (w_load) data <= r_shreg;
            rxdDataReady <= w_load;
            frameError   <= w_ferr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx_frame
// Description : Self-checking bench for uart_rx_frame. It runs directed
//               scenarios followed by randomized frames. Expected bytes and
//               error counts come from a frame-level reference queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_frame;

    localparam int CLK_FREQ   = 3200000;
    localparam int BAUD       = 100000;
    localparam int OVERSAMPLE = 16;
    localparam int BITCLK     = CLK_FREQ / BAUD;   // 32 clocks per bit

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] data;
    logic       rxdDataReady;
    logic       frameError;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parityError;
    bit         par_flip_g = 1'b0;
`endif

    uart_rx_frame #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .data         (data),
        .rxdDataReady (rxdDataReady),
        .frameError   (frameError),
        .busy         (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parityError  (parityError)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_log [0:255];
    int         rx_time [0:255];
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         both_cnt = 0;
    int         busy_at_strobe = 0;
    int         busy_cyc = 0;
    int         rd_ptr = 0;
    logic [7:0] exp_q [$];

    // Output monitor: logs strobes and counts events, sampled on the falling edge.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        busy_cyc <= busy_cyc + int'(busy);
        if (rxdDataReady) begin
            if (rx_cnt < 256) begin
                rx_log[rx_cnt]  <= data;
                rx_time[rx_cnt] <= cyc;
            end
            rx_cnt <= rx_cnt + 1;
            if (busy) busy_at_strobe <= busy_at_strobe + 1;
        end
        if (frameError) fe_cnt <= fe_cnt + 1;
        if (rxdDataReady && frameError) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parityError) pe_cnt <= pe_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int val, input int lo, input int hi);
        n_vec++;
        assert (val >= lo && val <= hi) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    // Drive one serial frame; optionally flip one clock at the centre of each data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch);
        hold(1'b0, BITCLK);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                hold(b[i], BITCLK / 2);
                hold(~b[i], 1);
                hold(b[i], BITCLK / 2 - 1);
            end else begin
                hold(b[i], BITCLK);
            end
        end
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_flip_g, BITCLK);
`endif
        hold(stop_v, BITCLK);
    endtask

    task automatic send_good(input logic [7:0] b, input bit glitch);
        send_frame(b, 1'b1, glitch);
        exp_q.push_back(b);
    endtask

    // Compare received bytes since the last call with the reference queue.
    task automatic expect_rx(input string tag);
        logic [7:0] e;
        check({tag, "_count"}, rx_cnt - rd_ptr, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr < rx_cnt) check({tag, "_data"}, {24'h0, rx_log[rd_ptr]}, {24'h0, e});
            rd_ptr++;
        end
        rd_ptr = rx_cnt;
    endtask

    initial begin
        int         t0;
        int         b0;
        int         f0;
        int         exp_fe;
        logic [7:0] rb;
        logic [7:0] pb;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_ready", {31'h0, rxdDataReady}, 32'h0);
        check("rst_ferr", {31'h0, frameError}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 40);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // Single byte A5 with latency window
        t0 = cyc;
        send_good(8'hA5, 1'b0);
        hold(1'b1, 64);
        check_rng("a5_latency", rx_time[0] - t0, 302, 316);
        expect_rx("a5");
        check("a5_data_port", {24'h0, data}, 32'hA5);
        check("a5_ferr", fe_cnt, 0);
        check("a5_busy_at_strobe", busy_at_strobe, 0);

        // Back-to-back 00 then FF
        send_good(8'h00, 1'b0);
        send_good(8'hFF, 1'b0);
        hold(1'b1, 64);
        expect_rx("b2b");

        // Short start glitch is rejected
        b0 = busy_cyc;
        hold(1'b0, 8);
        hold(1'b1, 60);
        check_rng("glitch_busy_cycles", busy_cyc - b0, 12, 20);
        check("glitch_busy_end", {31'h0, busy}, 32'h0);
        expect_rx("glitch");
        check("glitch_ferr", fe_cnt, 0);

        // Framing error, break, then recovery
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 500);
        hold(1'b1, 64);
        check("ferr_pulses", fe_cnt - f0, 1);
        expect_rx("ferr");
        check("ferr_data_kept", {24'h0, data}, 32'hFF);
        send_good(8'h12, 1'b0);
        hold(1'b1, 64);
        expect_rx("after_ferr");

        // Majority vote masks single-clock inversions
        send_good(8'h5A, 1'b1);
        hold(1'b1, 64);
        expect_rx("vote");

        // Reset during bit 4
        pb = 8'hC3;
        hold(1'b0, BITCLK);
        for (int i = 0; i < 4; i++) hold(pb[i], BITCLK);
        hold(pb[4], BITCLK / 2);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_ready", {31'h0, rxdDataReady}, 32'h0);
        rxd   = 1'b1;
        reset = 1'b1;
        hold(1'b1, 64);
        expect_rx("midrst");
        send_good(8'h7E, 1'b0);
        hold(1'b1, 64);
        expect_rx("after_rst");
`ifdef UART_RX_PARITY_EN
        b0 = pe_cnt;
        par_flip_g = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b0);
        par_flip_g = 1'b0;
        hold(1'b1, 64);
        check("parity_pulses", pe_cnt - b0, 1);
        expect_rx("parity");
`endif

        // Randomized frames against the reference queue
        f0     = fe_cnt;
        exp_fe = 0;
        for (int k = 0; k < 24; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send_frame(rb, 1'b0, 1'b0);
                hold(1'b0, $urandom_range(0, 100));
                hold(1'b1, 64);
                exp_fe++;
            end else begin
                send_good(rb, bit'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 40));
            end
        end
        hold(1'b1, 64);
        expect_rx("rand");
        check("rand_ferr", fe_cnt - f0, exp_fe);
        check("never_both", both_cnt, 0);
        check("busy_at_strobe", busy_at_strobe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
